// File: rtl/usr_seq_pkg.sv
// Shared encodings for the USR command sequencer: USR control codes,
// command opcodes and the sequencer FSM state type.
package usr_seq_pkg;

    // USR A[2:0] control codes
    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHL  = 3'b001;
    localparam logic [2:0] USR_SHR  = 3'b010;
    localparam logic [2:0] USR_CLR  = 3'b011;
    localparam logic [2:0] USR_PRE  = 3'b100;
    localparam logic [2:0] USR_UP   = 3'b101;
    localparam logic [2:0] USR_DN   = 3'b110;
    localparam logic [2:0] USR_LOAD = 3'b111;

    // Host command opcodes (cmd_op)
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SHL   = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_ROTL  = 3'd3;
    localparam logic [2:0] OP_ROTR  = 3'd4;
    localparam logic [2:0] OP_CNTUP = 3'd5;
    localparam logic [2:0] OP_CNTDN = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/usr_sequencer.sv
// Expands one host macro-command into the cycle-by-cycle USR control sequence.
// Optional macro USRSEQ_ABORT_EN adds an abort input that cuts LOAD/RUN short.
module usr_sequencer
    import usr_seq_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             reset,
`ifdef USRSEQ_ABORT_EN
    input  logic             abort,
`endif
    // Handshake: a command transfers on a Clk edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and cmd_valid while busy is simply ignored.
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] usr_q,
    output logic [2:0]       usr_a,
    output logic [WIDTH-1:0] usr_d,
    output logic             usr_rsi,
    output logic             usr_lsi,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] step_q;
    logic             fill_q;
    logic [WIDTH-1:0] result_q;
    logic             accept;
    logic             abort_req;

    assign accept = cmd_valid && (state == ST_IDLE);

`ifdef USRSEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command registers, step down-counter and the held result
    always_ff @(posedge Clk) begin
        if (reset) begin
            op_q     <= OP_NOP;
            data_q   <= '0;
            step_q   <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                step_q <= cmd_cnt;
                fill_q <= cmd_fill;
            end else if (state == ST_RUN) begin
                step_q <= step_q - CNT_W'(1);
            end
            if (state == ST_DONE) begin
                result_q <= usr_q;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (cmd_op == OP_NOP) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_req || (op_q == OP_CLEAR) || (step_q == '0)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // step_q never reaches 0 here; <= 1 keeps the exit robust anyway
                if (abort_req || (step_q <= CNT_W'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        usr_a     = USR_HOLD;
        usr_d     = '0;
        usr_rsi   = 1'b0;
        usr_lsi   = 1'b0;
        done      = 1'b0;
        result    = result_q;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_LOAD: begin
                usr_a = (op_q == OP_CLEAR) ? USR_CLR : USR_LOAD;
                usr_d = data_q;
            end
            ST_RUN: begin
                case (op_q)
                    OP_SHL: begin
                        usr_a   = USR_SHL;
                        usr_rsi = fill_q;
                    end
                    OP_SHR: begin
                        usr_a   = USR_SHR;
                        usr_lsi = fill_q;
                    end
                    OP_ROTL: begin
                        usr_a   = USR_SHL;
                        usr_rsi = usr_q[WIDTH-1];
                    end
                    OP_ROTR: begin
                        usr_a   = USR_SHR;
                        usr_lsi = usr_q[0];
                    end
                    OP_CNTUP: usr_a = USR_UP;
                    OP_CNTDN: usr_a = USR_DN;
                    default:  usr_a = USR_HOLD;
                endcase
            end
            ST_DONE: begin
                done   = 1'b1;
                result = usr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer paired with a behavioural 6-bit USR; results are
// predicted from closed-form shift/rotate/count arithmetic on each command.
module tb_usr_sequencer;
    import usr_seq_pkg::*;

    localparam int W  = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_cnt;
    logic          cmd_fill;
    logic [W-1:0]  usr_q;
    logic [2:0]    usr_a;
    logic [W-1:0]  usr_d;
    logic          usr_rsi;
    logic          usr_lsi;
    logic          done;
    logic [W-1:0]  result;
`ifdef USRSEQ_ABORT_EN
    logic          abort = 1'b0;
`endif

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q;
    int           n_checks = 0;
    int           n_fail   = 0;

    usr_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk      (clk),
        .reset    (reset),
`ifdef USRSEQ_ABORT_EN
        .abort    (abort),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_cnt  (cmd_cnt),
        .cmd_fill (cmd_fill),
        .usr_q    (usr_q),
        .usr_a    (usr_a),
        .usr_d    (usr_d),
        .usr_rsi  (usr_rsi),
        .usr_lsi  (usr_lsi),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift register driven by the sequencer
    always @(posedge clk) begin
        if (reset) begin
            usr_q <= '0;
        end else begin
            case (usr_a)
                USR_SHL:  usr_q <= {usr_q[W-2:0], usr_rsi};
                USR_SHR:  usr_q <= {usr_lsi, usr_q[W-1:1]};
                USR_CLR:  usr_q <= '0;
                USR_PRE:  usr_q <= '1;
                USR_UP:   usr_q <= usr_q + 1'b1;
                USR_DN:   usr_q <= usr_q - 1'b1;
                USR_LOAD: usr_q <= usr_d;
                default:  usr_q <= usr_q;
            endcase
        end
    end

    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] data,
                                                input int cnt, input logic fill, input logic [W-1:0] prior);
        int v, n, mask, fb;
        v = int'(data);
        mask = (1 << W) - 1;
        case (op)
            OP_NOP:   return prior;
            OP_CLEAR: return '0;
            OP_SHL: begin
                fb = fill ? ((1 << cnt) - 1) : 0;
                return W'(((v << cnt) | fb) & mask);
            end
            OP_SHR: begin
                fb = fill ? (mask & ~(mask >> cnt)) : 0;
                return W'((v >> cnt) | fb);
            end
            OP_ROTL: begin
                n = cnt % W;
                return W'(((v << n) | (v >> (W - n))) & mask);
            end
            OP_ROTR: begin
                n = cnt % W;
                return W'(((v >> n) | (v << (W - n))) & mask);
            end
            OP_CNTUP: return W'((v + cnt) & mask);
            OP_CNTDN: return W'((v - cnt) & mask);
            default:  return '0;
        endcase
    endfunction

    function automatic logic [2:0] run_code(input logic [2:0] op);
        case (op)
            OP_SHL, OP_ROTL: return USR_SHL;
            OP_SHR, OP_ROTR: return USR_SHR;
            OP_CNTUP:        return USR_UP;
            OP_CNTDN:        return USR_DN;
            default:         return USR_HOLD;
        endcase
    endfunction

    function automatic logic [W-1:0] step(input logic [2:0] op, input logic [W-1:0] v, input logic fill);
        case (op)
            OP_SHL:   return {v[W-2:0], fill};
            OP_SHR:   return {fill, v[W-1:1]};
            OP_ROTL:  return {v[W-2:0], v[W-1]};
            OP_ROTR:  return {v[0], v[W-1:1]};
            OP_CNTUP: return v + 1'b1;
            OP_CNTDN: return v - 1'b1;
            default:  return v;
        endcase
    endfunction

    // Presents one command in an IDLE cycle; returns 1 time unit after the accept edge
    task automatic issue(input logic [2:0] op, input logic [W-1:0] data, input logic [CW-1:0] cnt,
                         input logic fill, input bit hold);
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: got %b want 1", cmd_ready);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: got %b want 0", done);
        end
        n_checks++;
        if (result !== model_q) begin
            n_fail++;
            $display("FAIL result_hold: got %b want %b", result, model_q);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        exp_q.push_back(ref_result(op, data, int'(cnt), fill, model_q));
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Checks every cycle after the accept edge; cut > 0 stops after that cycle
    task automatic follow_cmd(input logic [2:0] op, input logic [W-1:0] data, input int cnt,
                              input logic fill, input int cut);
        int           lat;
        logic [W-1:0] cur;
        logic [W-1:0] exp_res;
        logic [2:0]   ea;
        logic         ersi;
        logic         elsi;
        lat = (op == OP_NOP) ? 1 : (op == OP_CLEAR) ? 2 : cnt + 2;
        cur = model_q;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            ea = USR_HOLD;
            ersi = 1'b0;
            elsi = 1'b0;
            if (k != lat && k == 1) begin
                ea = (op == OP_CLEAR) ? USR_CLR : USR_LOAD;
                n_checks++;
                if (usr_d !== data) begin
                    n_fail++;
                    $display("FAIL load_data: got %b want %b", usr_d, data);
                end
            end else if (k != lat) begin
                ea = run_code(op);
                if (op == OP_SHL)  ersi = fill;
                if (op == OP_SHR)  elsi = fill;
                if (op == OP_ROTL) ersi = cur[W-1];
                if (op == OP_ROTR) elsi = cur[0];
            end
            n_checks++;
            if (usr_a !== ea) begin
                n_fail++;
                $display("FAIL usr_a op%0d cyc%0d: got %b want %b", op, k, usr_a, ea);
            end
            n_checks++;
            if (usr_rsi !== ersi || usr_lsi !== elsi) begin
                n_fail++;
                $display("FAIL serial_in op%0d cyc%0d: got rsi=%b lsi=%b want rsi=%b lsi=%b",
                         op, k, usr_rsi, usr_lsi, ersi, elsi);
            end
            n_checks++;
            if (cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ready cyc%0d: got %b want 0", k, cmd_ready);
            end
            n_checks++;
            if (done !== (k == lat)) begin
                n_fail++;
                $display("FAIL done_timing op%0d cyc%0d: got %b want %b", op, k, done, (k == lat));
            end
            if (k == lat) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: got 0 entries want 1");
                end else begin
                    exp_res = exp_q.pop_front();
                    if (result !== exp_res) begin
                        n_fail++;
                        $display("FAIL result op%0d: got %b want %b", op, result, exp_res);
                    end
                    model_q = exp_res;
                end
            end
            if (k == cut) return;
            if (k == 1) cur = (op == OP_CLEAR) ? '0 : data;
            else        cur = step(op, cur, fill);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] data, input int cnt, input logic fill);
        issue(op, data, CW'(cnt), fill, 1'b0);
        follow_cmd(op, data, cnt, fill, 0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = OP_NOP;
        cmd_data = '0;
        cmd_cnt = '0;
        cmd_fill = 1'b0;
        model_q = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: got ready=%b done=%b want ready=1 done=0", cmd_ready, done);
        end
        n_checks++;
        if (usr_a !== USR_HOLD || usr_d !== '0 || usr_rsi !== 1'b0 || usr_lsi !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_usr: got a=%b d=%b rsi=%b lsi=%b want all 0", usr_a, usr_d, usr_rsi, usr_lsi);
        end
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %b want 000000", result);
        end
    endtask

    task automatic test_directed;
        run_cmd(OP_SHL,   6'b101010, 2, 1'b1);
        run_cmd(OP_ROTR,  6'b000011, 3, 1'b0);
        run_cmd(OP_CNTDN, 6'b000000, 1, 1'b0);
        run_cmd(OP_CNTUP, 6'b111111, 2, 1'b0);
        run_cmd(OP_SHR,   6'b110011, 0, 1'b1);
        run_cmd(OP_NOP,   6'b000101, 7, 1'b1);
        run_cmd(OP_ROTL,  6'b100101, 15, 1'b0);
        run_cmd(OP_SHR,   6'b010110, 3, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] d;
        d = W'($urandom());
        issue(OP_ROTL, 6'b110010, CW'(10), 1'b0, 1'b0);
        follow_cmd(OP_ROTL, 6'b110010, 10, 1'b0, 5);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (usr_a !== USR_HOLD || cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: got a=%b ready=%b done=%b want a=000 ready=1 done=0", usr_a, cmd_ready, done);
        end
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL midreset_result: got %b want 000000", result);
        end
        reset = 1'b0;
        model_q = '0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: got done=%b ready=%b want done=0 ready=1", done, cmd_ready);
        end
        run_cmd(OP_CLEAR, d, int'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] da;
        logic [W-1:0] db;
        int           ca;
        int           cb;
        da = W'($urandom());
        db = W'($urandom());
        ca = int'($urandom_range(1, 6));
        cb = int'($urandom_range(0, 6));
        issue(OP_SHL, da, CW'(ca), 1'b1, 1'b1);
        cmd_op   = OP_CNTUP;
        cmd_data = db;
        cmd_cnt  = CW'(cb);
        cmd_fill = 1'b0;
        follow_cmd(OP_SHL, da, ca, 1'b1, 0);
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got ready=%b done=%b want ready=1 done=0", cmd_ready, done);
        end
        exp_q.push_back(ref_result(OP_CNTUP, db, cb, 1'b0, model_q));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        follow_cmd(OP_CNTUP, db, cb, 1'b0, 0);
    endtask

    task automatic test_random;
        logic [2:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            run_cmd(op, W'($urandom()), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usr_sequencer.md
Name: usr_sequencer

Overview:
- Command-driven controller for the 6-bit universal shift register (USR).
- Accepts one macro-command per valid/ready handshake: load, shift, rotate, count or clear, with a repeat count.
- Expands each command into the cycle-by-cycle A/D/RSI/LSI sequence the USR needs, then reports the final Q.
- Sits between a host FSM and one USR instance; USR Q is fed back for rotate operations.

Parameters:
- WIDTH, 6, USR data width (d/Q/result).
- CNT_W, 4, repeat-count width (max 15 steps per command).

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; also tied to the USR reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  0 NOP, 1 SHL, 2 SHR, 3 ROTL, 4 ROTR, 5 CNTUP, 6 CNTDN, 7 CLEAR.
- cmd_data  in  WIDTH  initial value loaded into the USR.
- cmd_cnt  in  CNT_W  number of step cycles.
- cmd_fill  in  1  fill bit for SHL/SHR.
- usr_q  in  WIDTH  USR Q feedback.
- usr_a  out  3  USR control code.
- usr_d  out  WIDTH  USR parallel data.
- usr_rsi  out  1  USR right serial in (LSB fill on left shift).
- usr_lsi  out  1  USR left serial in (MSB fill on right shift).
- done  out  1  one-cycle pulse, command finished.
- result  out  WIDTH  final USR value.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high, named reset.
- Reset values:
  - State goes to IDLE.
  - usr_a=000 (hold), usr_d=0, usr_rsi=0, usr_lsi=0.
  - done=0, result=0, cmd_ready=1 in the first cycle after reset deasserts.
- Command capture: on a Clk edge with cmd_valid&&cmd_ready, cmd_op/data/cnt/fill are registered. cmd_valid while busy is ignored, with no queueing.
- FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE.
  - IDLE: usr_a=000.
  - LOAD (1 cycle): usr_a=111, usr_d=data. NOP skips LOAD and goes straight to DONE. CLEAR uses usr_a=011 in LOAD, then goes to DONE.
  - RUN (cnt cycles, skipped if cnt=0):
    - SHL: usr_a=001, rsi=fill.
    - SHR: usr_a=010, lsi=fill.
    - ROTL: usr_a=001, rsi=usr_q[WIDTH-1] (combinational).
    - ROTR: usr_a=010, lsi=usr_q[0].
    - CNTUP: usr_a=101.
    - CNTDN: usr_a=110.
    - A step counter decrements each RUN edge; exit when it reaches 1.
  - DONE (1 cycle): usr_a=000, done=1, result=usr_q. Leaving DONE latches usr_q into a result register; result then holds that value until the next DONE.
- Latency: busy time is cnt+2 cycles (1 for NOP).
  - done is high in the (cnt+2)th cycle after the accept edge.
  - Back-to-back throughput is one command per cnt+3 cycles.
- Outside LOAD/RUN, rsi/lsi=0.
- Arithmetic wrap in CNTUP/CNTDN (111111+1 → 000000) is the USR's responsibility; the sequencer only counts steps.
- Reset mid-command: the command is dropped and no done is issued. USR is also reset (Q=0). The next cycle is IDLE with ready=1.

Optional Feature:
- USRSEQ_ABORT_EN: adds input port abort (1 bit).
  - When it is set, abort in LOAD or RUN forces the next state to DONE.
  - done pulses with result=current usr_q; the remaining steps are discarded.
  - abort in IDLE/DONE has no effect.
- Without the macro: the port is absent and commands always run to completion.

Decomposition:
- Package usr_seq_pkg:
  - USR control localparams: HOLD=000, SHL=001, SHR=010, CLR=011, PRE=100, UP=101, DN=110, LOAD=111.
  - cmd_op encodings.
  - FSM state encoding (2 bits).
- No sub-module needed. The step counter is a small inline down-counter.
- The bench pairs the sequencer with the real USR.

Test Plan:
- SHL, data=101010, cnt=2, fill=1 → usr_a sequence 111,001,001,000; done on 4th cycle after accept; result=101011.
- ROTR, data=000011, cnt=3 → Q 100001, 110000, 011000; result=011000; lsi tracks Q[0] each RUN cycle.
- CNTDN, data=000000, cnt=1 → result=111111 (wrap). Then CNTUP, data=111111, cnt=2 → result=000001.
- SHR, data=110011, cnt=0 → only LOAD then DONE; result=110011, done 2 cycles after accept. NOP → done 1 cycle after accept, result=current Q.
- ROTL, cnt=10, reset asserted in 4th RUN cycle → no done; usr_a=000, ready=1 next cycle. A following CLEAR completes with result=000000.
- cmd_valid held high continuously with two commands → second accepted only on the IDLE edge after done; ready low for all busy cycles.
